// File: rtl/j1_io_pkg.sv
// Shared types and constants for the J1 io arbiter: FSM state encoding,
// io word width and the default host pending limit.
package j1_io_pkg;

  localparam int IO_W            = 16;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/j1_io_arbiter.sv
// J1 io bus arbiter: CPU owns the peripheral bus with zero latency, host gets
// idle slots. Optional PEND timeout enabled by macro J1_IO_ARB_TIMEOUT_EN.
module j1_io_arbiter
  import j1_io_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_n_i,
  input  logic            cpu_io_rd,
  input  logic            cpu_io_wr,
  input  logic [IO_W-1:0] cpu_io_addr,
  input  logic [IO_W-1:0] cpu_io_dout,
  output logic [IO_W-1:0] cpu_io_din,
  input  logic            host_req,
  input  logic            host_we,
  input  logic [IO_W-1:0] host_addr,
  input  logic [IO_W-1:0] host_wdata,
  output logic            host_ack,
  output logic            host_err,
  output logic [IO_W-1:0] host_rdata,
  output logic            per_rd,
  output logic            per_wr,
  output logic [IO_W-1:0] per_addr,
  output logic [IO_W-1:0] per_wdata,
  input  logic [IO_W-1:0] per_rdata,
  output logic            per_owner
);

  arb_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [IO_W-1:0] addr_q, addr_d;
  logic [IO_W-1:0] wdata_q, wdata_d;
  logic [IO_W-1:0] rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic            cpu_busy;
  logic            host_slot;
  logic            timeout_hit;

  assign cpu_busy  = cpu_io_rd | cpu_io_wr;
  // Gating with reset keeps the host path silent while reset is asserted.
  assign host_slot = (state_q == ST_PEND) && !cpu_busy && sys_rst_n_i;

  always_comb begin
    per_rd    = 1'b0;
    per_wr    = 1'b0;
    per_addr  = '0;
    per_wdata = '0;
    per_owner = 1'b0;
    if (cpu_busy) begin
      per_rd    = cpu_io_rd;
      per_wr    = cpu_io_wr;
      per_addr  = cpu_io_addr;
      per_wdata = cpu_io_dout;
    end else if (host_slot) begin
      per_rd    = ~we_q;
      per_wr    = we_q;
      per_addr  = addr_q;
      per_wdata = wdata_q;
      per_owner = 1'b1;
    end
  end

  assign cpu_io_din = per_rdata;
  assign host_rdata = rdata_q;
  assign host_ack   = ack_q & sys_rst_n_i;

`ifdef J1_IO_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q;

  assign timeout_hit = (state_q == ST_PEND) && cpu_busy &&
                       (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && host_req) begin
      cnt_d = '0;
    end else if (state_q == ST_PEND && cpu_busy) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout_hit;
    end
  end

  assign host_err = err_q & sys_rst_n_i;
`else
  assign timeout_hit = 1'b0;
  assign host_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (host_req) begin
          we_d    = host_we;
          addr_d  = host_addr;
          wdata_d = host_wdata;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (host_slot) begin
          if (!we_q) begin
            rdata_d = per_rdata;
          end
          ack_d   = 1'b1;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          // Abort path: no strobe was issued, read data stays as it was.
          ack_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

endmodule

// File: doc/j1_io_arbiter.md
J1_IO_ARBITER -- requirements
Module: j1_io_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum host pending cycles before abort (range 1..255).
REQ-002 SHALL have port sys_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports cpu_io_rd/cpu_io_wr  input  1 each  J1 io strobes (combinational from the J1 instruction).
REQ-005 SHALL have ports cpu_io_addr/cpu_io_dout  input  16 each  J1 io address and write data.
REQ-006 SHALL have port cpu_io_din  output  16  read data returned to J1.
REQ-007 SHALL have ports host_req/host_we  input  1 each  host (debug/DMA) request and write-select.
REQ-008 SHALL have ports host_addr/host_wdata  input  16 each  host address and write data.
REQ-009 SHALL have ports host_ack/host_err  output  1 each  one-cycle completion pulse and abort flag.
REQ-010 SHALL have port host_rdata  output  16  registered host read data.
REQ-011 SHALL have ports per_rd/per_wr  output  1 each  peripheral bus strobes.
REQ-012 SHALL have ports per_addr/per_wdata  output  16 each  peripheral address and write data.
REQ-013 SHALL have port per_rdata  input  16  peripheral read data (combinational).
REQ-014 SHALL have port per_owner  output  1  0=CPU or idle, 1=host drives the peripheral bus this cycle.

Function
REQ-015 SHALL give the CPU absolute priority: the CPU never stalls, and cpu_io_* SHALL pass to per_* combinationally with zero latency.
REQ-016 SHALL drive cpu_io_din = per_rdata combinationally in every cycle.
REQ-017 SHALL pass cpu_io_rd and cpu_io_wr through unchanged when both are high in the same cycle.
REQ-018 SHALL implement the FSM IDLE, PEND and DONE.
REQ-019 IDLE: on host_req=1, SHALL latch host_we, host_addr and host_wdata, then enter PEND.
REQ-020 PEND: a host slot SHALL exist in any cycle with cpu_io_rd=0 and cpu_io_wr=0; this decision is combinational in the same cycle.
REQ-021 In a host slot the block SHALL drive per_owner=1, per_addr and per_wdata from the latched fields, and per_rd=~we or per_wr=we for exactly one cycle.
REQ-022 In a host slot the block SHALL capture per_rdata into host_rdata on a read (hold it on a write), then enter DONE.
REQ-023 DONE: SHALL assert host_ack=1 for one cycle, then enter IDLE; host_req still high in IDLE SHALL start a new transaction (minimum 3 cycles per host access).
REQ-024 Host fields are sampled only in IDLE; changes during PEND/DONE SHALL be ignored.
REQ-025 When the bus is idle, per_* SHALL be 0, per_owner SHALL be 0 and no strobe SHALL be driven.
REQ-026 A CPU access in a PEND cycle SHALL defer the host; the host SHALL never preempt or corrupt a CPU access.

Reset
REQ-027 sys_rst_n_i=0 at a clock edge SHALL force: state IDLE; host_ack=0; host_err=0; host_rdata=0; latched fields=0; timeout counter=0.
REQ-028 Reset mid-PEND or mid-DONE SHALL drop the transaction with no ack and no peripheral strobe.
REQ-029 CPU pass-through stays combinational during reset; the host path SHALL be inert during reset.

Configuration
REQ-030 With macro J1_IO_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on PEND entry and increment each deferred PEND cycle.
REQ-031 With J1_IO_ARB_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES SHALL move PEND to DONE with no strobe, host_err=1 with host_ack, and host_rdata unchanged; host_err SHALL clear on the next cycle.
REQ-032 Without J1_IO_ARB_TIMEOUT_EN, PEND SHALL wait indefinitely, host_err SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-033 Package j1_io_pkg SHALL hold the FSM state enum (IDLE/PEND/DONE), the default TIMEOUT_CYCLES constant and the 16-bit io word width.
REQ-034 SHALL be a single module with no sub-module; the arbitration and FSM are too small to split.

Verification
REQ-035 CPU write: cpu_io_wr=1, addr=0xF000, dout=0x1234 -> per_wr=1, per_addr=0xF000, per_wdata=0x1234 in the same cycle, per_owner=0.
REQ-036 Host read on an idle CPU: req, we=0, addr=0xE000, per_rdata=0xBEEF -> per_rd one cycle after the IDLE edge, host_rdata=0xBEEF and host_ack on the next cycle.
REQ-037 Contention: CPU strobes active 5 consecutive cycles while host_req is high -> no host strobe during those cycles, host strobe in cycle 6, ack in cycle 7.
REQ-038 Back-to-back: host_req held high for two writes -> exactly two per_wr host pulses, two ack pulses, spacing of 3 cycles.
REQ-039 Timeout (macro on, TIMEOUT_CYCLES=4): CPU busy continuously -> after 4 deferred cycles, ack=1 and err=1, no per strobe; macro off -> no ack until the CPU goes idle.
REQ-040 Reset mid-PEND: drop sys_rst_n_i for 1 cycle -> no ack, no strobe, state IDLE, host_rdata=0.
